// File: rtl/axi_timer_multi.sv
// AXI4-lite slave with CHANNEL_NBR_p compare timers sharing one prescaler.
// Each channel counts prescaler ticks up to CMP and raises a registered level interrupt.
module axi_timer_multi #(
    parameter int AXI_ADDR_BW_p  = 12,
    parameter int CHANNEL_NBR_p  = 4,
    parameter int CNT_BW_p       = 32,
    parameter int PRESCALER_BW_p = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    output logic [CHANNEL_NBR_p-1:0] o_irq
);
    localparam int AW = AXI_ADDR_BW_p;
    localparam logic [AW-1:0] ADDR_PRESCALE = AW'(12'h800);
    localparam logic [AW-1:0] ADDR_IRQ_SUM  = AW'(12'h804);
    localparam logic [1:0]    RESP_OKAY     = 2'b00;
    localparam logic [1:0]    RESP_SLVERR   = 2'b10;

    logic [2:0]                ctrl_q [CHANNEL_NBR_p];
    logic [2:0]                ctrl_d [CHANNEL_NBR_p];
    logic [CNT_BW_p-1:0]       cmp_q  [CHANNEL_NBR_p];
    logic [CNT_BW_p-1:0]       cmp_d  [CHANNEL_NBR_p];
    logic [CNT_BW_p-1:0]       cnt_q  [CHANNEL_NBR_p];
    logic [CNT_BW_p-1:0]       cnt_d  [CHANNEL_NBR_p];
    logic [CHANNEL_NBR_p-1:0]  done_q, done_d, done_set;
    logic [CHANNEL_NBR_p-1:0]  irq_q, irq_d;
    logic [PRESCALER_BW_p-1:0] prescale_q, prescale_d;
    logic [PRESCALER_BW_p-1:0] pcnt_q, pcnt_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [31:0]               rdata_q, rdata_d;

    logic                      wr_acc, rd_acc, tick;
    logic [AW-1:0]             wr_addr, rd_addr;
    logic [1:0]                wr_off, rd_off;
    logic [CHANNEL_NBR_p-1:0]  wr_ch_hit, rd_ch_hit, sw_owns;
    logic                      wr_is_pre, wr_ok, rd_ok;
    logic [31:0]               rd_data;
    logic                      unused_bits;

    assign unused_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0], i_axi_wdata};

    assign wr_acc  = i_axi_awvalid & i_axi_wvalid & ~bvalid_q & ~rst;
    assign rd_acc  = i_axi_arvalid & ~rvalid_q & ~rst;
    assign wr_addr = {i_axi_awaddr[AW-1:2], 2'b00};
    assign rd_addr = {i_axi_araddr[AW-1:2], 2'b00};
    assign wr_off  = wr_addr[3:2];
    assign rd_off  = rd_addr[3:2];
    assign tick    = (pcnt_q == prescale_q);

    for (genvar n = 0; n < CHANNEL_NBR_p; n++) begin : g_dec
        assign wr_ch_hit[n] = (wr_addr[AW-1:8] == '0) && (wr_addr[7:4] == 4'(n));
        assign rd_ch_hit[n] = (rd_addr[AW-1:8] == '0) && (rd_addr[7:4] == 4'(n));
        // A CTRL or CNT write takes the whole channel step for that cycle.
        assign sw_owns[n]   = wr_acc && wr_ch_hit[n] && !wr_off[0];
    end

    assign wr_is_pre = (wr_addr == ADDR_PRESCALE);
    assign wr_ok     = (|wr_ch_hit) | wr_is_pre;

    always_comb begin
        done_set = '0;
        done_d   = done_q;
        irq_d    = '0;
        for (int n = 0; n < CHANNEL_NBR_p; n++) begin
            ctrl_d[n] = ctrl_q[n];
            cmp_d[n]  = cmp_q[n];
            cnt_d[n]  = cnt_q[n];
            if (tick && ctrl_q[n][0] && !sw_owns[n]) begin
                if (cnt_q[n] == cmp_q[n]) begin
                    done_set[n] = 1'b1;
                    if (ctrl_q[n][1]) begin
                        cnt_d[n] = '0;
                    end else begin
                        ctrl_d[n][0] = 1'b0;
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_BW_p'(1);
                end
            end
            done_d[n] = done_q[n] | done_set[n];
            if (wr_acc && wr_ch_hit[n]) begin
                case (wr_off)
                    2'd0:    ctrl_d[n] = i_axi_wdata[2:0];
                    2'd1:    cmp_d[n]  = i_axi_wdata[CNT_BW_p-1:0];
                    2'd2:    cnt_d[n]  = i_axi_wdata[CNT_BW_p-1:0];
                    default: begin
                        // A hardware set in the same cycle keeps DONE high.
                        if (i_axi_wdata[0] && !done_set[n]) begin
                            done_d[n] = 1'b0;
                        end
                    end
                endcase
            end
            irq_d[n] = done_q[n] & ctrl_q[n][2];
        end
    end

    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = tick ? '0 : pcnt_q + PRESCALER_BW_p'(1);
        if (wr_acc && wr_is_pre) begin
            prescale_d = i_axi_wdata[PRESCALER_BW_p-1:0];
            pcnt_d     = '0;
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_acc) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && i_axi_bready) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b0;
        for (int n = 0; n < CHANNEL_NBR_p; n++) begin
            if (rd_ch_hit[n]) begin
                rd_ok = 1'b1;
                case (rd_off)
                    2'd0:    rd_data = 32'(ctrl_q[n]);
                    2'd1:    rd_data = 32'(cmp_q[n]);
                    2'd2:    rd_data = 32'(cnt_q[n]);
                    default: rd_data = {31'b0, done_q[n]};
                endcase
            end
        end
        if (rd_addr == ADDR_PRESCALE) begin
            rd_ok   = 1'b1;
            rd_data = 32'(prescale_q);
        end else if (rd_addr == ADDR_IRQ_SUM) begin
            rd_ok   = 1'b1;
            rd_data = 32'(irq_q);
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_data;
        end else if (rvalid_q && i_axi_rready) begin
            rvalid_d = 1'b0;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '{default: '0};
            cmp_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            done_q     <= '0;
            irq_q      <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            cmp_q      <= cmp_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_axi_awready = wr_acc;
    assign o_axi_wready  = wr_acc;
    assign o_axi_arready = rd_acc;
    assign o_axi_bvalid  = bvalid_q;
    assign o_axi_bresp   = bresp_q;
    assign o_axi_rvalid  = rvalid_q;
    assign o_axi_rresp   = rresp_q;
    assign o_axi_rdata   = rdata_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_axi_timer_multi.sv
// Directed bench for axi_timer_multi: reset, auto-reload, one-shot, collisions, bus errors, backpressure.
module tb_axi_timer_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic [3:0]  irq;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp, last_bresp;
    int          last_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_timer_multi #(
        .AXI_ADDR_BW_p(12), .CHANNEL_NBR_p(4), .CNT_BW_p(32), .PRESCALER_BW_p(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
        .i_axi_wdata(wdata), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
        .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
        .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
        .o_irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the B handshake.
    task automatic axi_wr(input logic [11:0] addr, input logic [31:0] data);
        bit got = 0;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        last_acc = -1000; last_bresp = 2'bxx;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (awready && wready) begin got = 1; last_acc = cyc + 1; end
            else @(negedge clk);
        end
        if (!got) begin
            awvalid = 1'b0; wvalid = 1'b0;
            chk("wr_accept_timeout", 32'(got), 1);
            return;
        end
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin got = 1; last_bresp = bresp; end
            else @(negedge clk);
        end
        if (!got) begin chk("wr_bvalid_timeout", 32'(got), 1); return; end
        @(negedge clk);
    endtask

    task automatic axi_rd(input logic [11:0] addr);
        bit got = 0;
        araddr = addr; arvalid = 1'b1;
        last_rdata = 'x; last_rresp = 2'bxx;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (arready) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            arvalid = 1'b0;
            chk("rd_accept_timeout", 32'(got), 1);
            return;
        end
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin got = 1; last_rdata = rdata; last_rresp = rresp; end
            else @(negedge clk);
        end
        if (!got) begin chk("rd_rvalid_timeout", 32'(got), 1); return; end
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        axi_rd(addr);
        chk(tag, last_rdata, exp);
    endtask

    task automatic poll_irq(input int b, output int t);
        t = -1000;
        for (int i = 0; i < 40; i++) begin
            if (irq[b]) begin t = cyc; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, p, c, t;
        bit seen, stable;

        // Reset held for 2 clocks while a write is being offered.
        rst = 1'b1; awaddr = 12'h004; wdata = 32'hAB; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {29'b0, awready, wready, arready}, 0);
        chk("rst_valid", {30'b0, bvalid, rvalid}, 0);
        chk("rst_resp", {28'b0, bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", {28'b0, irq}, 0);
        rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= bvalid; end
        chk("rst_no_bvalid", 32'(seen), 0);
        for (int ch = 0; ch < 4; ch++)
            for (int off = 0; off < 4; off++)
                rd_chk($sformatf("rst_reg_%03h", ch * 16 + off * 4), 12'(ch * 16 + off * 4), 0);
        rd_chk("rst_prescale", 12'h800, 0);

        // Auto-reload ch0, PRESCALE=0, CMP=4: DONE every 5 clocks.
        axi_wr(12'h004, 4);
        axi_wr(12'h000, 7);
        e = last_acc;
        poll_irq(0, t);
        chk("ar_irq_first", 32'(t - e), 6);
        wait_cyc(e + 6);
        axi_wr(12'h00C, 1);
        chk("ar_w1c_irq_low", {31'b0, irq[0]}, 0);
        poll_irq(0, t);
        chk("ar_irq_second", 32'(t - e), 11);
        wait_cyc(e + 11);
        axi_wr(12'h00C, 1);
        wait_cyc(e + 14);
        axi_wr(12'h00C, 1);
        chk("w1c_vs_done_irq", {31'b0, irq[0]}, 1);
        rd_chk("w1c_vs_done_status", 12'h00C, 1);
        axi_wr(12'h000, 4);
        axi_wr(12'h00C, 1);
        chk("ch0_off_irq_low", {31'b0, irq[0]}, 0);
        rd_chk("ch0_off_status", 12'h00C, 0);

        // One-shot ch2, PRESCALE=3, CMP=2, CTRL=EN|IRQ_EN.
        axi_wr(12'h800, 3);
        p = last_acc;
        axi_wr(12'h024, 2);
        axi_wr(12'h020, 5);
        c = last_acc;
        chk("os_ctrl_on_tick", 32'(c - p), 4);
        poll_irq(2, t);
        chk("os_irq_delay", 32'(t - c), 13);
        rd_chk("os_cnt_hold", 12'h028, 2);
        rd_chk("os_ctrl_en_cleared", 12'h020, 4);
        rd_chk("os_status", 12'h02C, 1);
        rd_chk("irq_summary", 12'h804, 4);
        axi_wr(12'h02C, 1);
        rd_chk("irq_summary_clr", 12'h804, 0);

        // Software CNT write in a tick cycle beats the increment.
        axi_wr(12'h014, 100);
        axi_wr(12'h010, 1);
        axi_wr(12'h800, 3);
        p = last_acc;
        wait_cyc(p + 3);
        axi_wr(12'h018, 9);
        chk("cnt_wr_on_tick", 32'(last_acc - p), 4);
        axi_wr(12'h010, 0);
        rd_chk("cnt_wr_wins", 12'h018, 9);

        // Bus errors.
        axi_rd(12'h040);
        chk("err_rd_resp", {30'b0, last_rresp}, 2);
        chk("err_rd_data", last_rdata, 0);
        axi_wr(12'h804, 32'hF);
        chk("err_wr_sum_resp", {30'b0, last_bresp}, 2);
        axi_wr(12'h040, 1);
        chk("err_wr_ch4_resp", {30'b0, last_bresp}, 2);
        axi_rd(12'h900);
        chk("err_rd_900_resp", {30'b0, last_rresp}, 2);
        axi_rd(12'h804);
        chk("ok_rd_sum_resp", {30'b0, last_rresp}, 0);

        // Write backpressure: second write held off until the B handshake.
        bready = 1'b0;
        awaddr = 12'h034; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("bp_first_accept", {30'b0, awready, wready}, 3);
        @(posedge clk); @(negedge clk);
        awaddr = 12'h038; wdata = 32'h66;
        stable = 1;
        repeat (10) begin
            #1;
            if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) stable = 0;
            @(negedge clk);
        end
        chk("bp_b_hold", 32'(stable), 1);
        bready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_second_accept", {30'b0, bvalid, awready}, 1);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_bvalid", {31'b0, bvalid}, 1);
        @(negedge clk);
        rd_chk("bp_cmp3", 12'h034, 32'h55);
        rd_chk("bp_cnt3", 12'h038, 32'h66);

        // Read backpressure: rdata held while the register changes underneath.
        rready = 1'b0;
        araddr = 12'h034; arvalid = 1'b1;
        #1;
        chk("rbp_accept", {31'b0, arready}, 1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        axi_wr(12'h034, 32'h77);
        araddr = 12'h038; arvalid = 1'b1;
        stable = 1;
        repeat (10) begin
            #1;
            if (!(rvalid === 1'b1 && rdata === 32'h55 && rresp === 2'b00 && arready === 1'b0)) stable = 0;
            @(negedge clk);
        end
        chk("rbp_r_hold", 32'(stable), 1);
        rready = 1'b1;
        @(negedge clk);
        #1;
        chk("rbp_second_accept", {30'b0, rvalid, arready}, 1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        chk("rbp_second_data", rdata, 32'h66);
        @(negedge clk);
        rd_chk("rbp_cmp3_written", 12'h034, 32'h77);

        // Read and write to the same register in one cycle: read sees the old value.
        araddr = 12'h034; arvalid = 1'b1;
        awaddr = 12'h034; wdata = 32'h5A; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("rw_both_accept", {30'b0, arready, awready}, 3);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("rw_read_old", rdata, 32'h77);
        @(negedge clk);
        rd_chk("rw_new_value", 12'h034, 32'h5A);

        // Reset aborts a pending write response.
        bready = 1'b0;
        awaddr = 12'h800; wdata = 32'h9; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("abort_pre_bvalid", {31'b0, bvalid}, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_bvalid_low", {31'b0, bvalid}, 0);
        rst = 1'b0; bready = 1'b1;
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= bvalid; end
        chk("abort_no_bresp", 32'(seen), 0);
        rd_chk("abort_prescale_cleared", 12'h800, 0);
        rd_chk("abort_cmp3_cleared", 12'h034, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
